// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator drain stage.
package acc_pkg;

  localparam int unsigned DEF_WORD_LEN = 24;
  localparam int unsigned ACC_W        = 2 * DEF_WORD_LEN;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Accumulator width for a given sample width.
  function automatic int unsigned acc_w(input int unsigned word_len);
    return 2 * word_len;
  endfunction

  // PE index width; at least one bit.
  function automatic int unsigned idx_w(input int unsigned num_pe);
    return (num_pe > 1) ? $clog2(num_pe) : 1;
  endfunction

  // Largest signed value representable in w bits.
  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest signed value representable in w bits.
  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/acc_drain_if.sv
// Output sample stream of the drain stage (valid/ready).
interface acc_drain_if
  import acc_pkg::*;
#(
  parameter int unsigned WORD_LEN = 24,
  parameter int unsigned NUM_PE   = 8
);
  localparam int unsigned IW = idx_w(NUM_PE);

  logic                       out_valid;
  logic                       out_ready;
  logic signed [WORD_LEN-1:0] out_R;
  logic signed [WORD_LEN-1:0] out_I;
  logic [IW-1:0]              out_idx;

  modport master (output out_valid, out_R, out_I, out_idx, input out_ready);
  modport slave  (input out_valid, out_R, out_I, out_idx, output out_ready);
endinterface

// File: rtl/acc_round_sat.sv
// Round-half-up, arithmetic shift and saturate one accumulator to WORD_LEN.
module acc_round_sat
  import acc_pkg::*;
#(
  parameter int unsigned WORD_LEN = 24,
  parameter int unsigned SHIFT    = 8
) (
  input  logic [2*WORD_LEN-1:0]      acc,
  output logic signed [WORD_LEN-1:0] y,
  output logic                       sat
);
  localparam int unsigned AW = acc_w(WORD_LEN);
  // One guard bit keeps the rounding add from wrapping at full scale.
  localparam int unsigned EW = AW + 1;
  localparam logic signed [EW-1:0] RND_K = (SHIFT > 0) ? (EW'(1) << (SHIFT - 1)) : '0;
  localparam logic signed [EW-1:0] HI    = EW'(sat_max(WORD_LEN));
  localparam logic signed [EW-1:0] LO    = EW'(sat_min(WORD_LEN));

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] shf;

  // Sign-extend, round, shift, clamp.
  always_comb begin
    ext = {acc[AW-1], acc};
    rnd = ext + RND_K;
    shf = rnd >>> SHIFT;
    sat = 1'b0;
    y   = WORD_LEN'(shf);
    if (shf > HI) begin
      y   = WORD_LEN'(HI);
      sat = 1'b1;
    end else if (shf < LO) begin
      y   = WORD_LEN'(LO);
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/acc_drain.sv
// Snapshot NUM_PE complex accumulators and stream them out scaled, one PE per
// transfer. Optional macro ACC_DRAIN_SAT_CNT_EN adds a saturated-sample counter.
module acc_drain
  import acc_pkg::*;
#(
  parameter int unsigned WORD_LEN = 24,
  parameter int unsigned NUM_PE   = 8,
  parameter int unsigned SHIFT    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         capture,
  input  logic [NUM_PE*2*WORD_LEN-1:0] acc_R,
  input  logic [NUM_PE*2*WORD_LEN-1:0] acc_I,
  output logic                         busy,
  output logic                         done,
  output logic                         capture_drop,
`ifdef ACC_DRAIN_SAT_CNT_EN
  output logic [15:0]                  sat_cnt,
`endif
  acc_drain_if.master                  out_if
);
  localparam int unsigned AW = acc_w(WORD_LEN);
  localparam int unsigned IW = idx_w(NUM_PE);
  localparam logic [IW-1:0] LAST = IW'(NUM_PE - 1);

  state_t                     state_q, state_d;
  logic [AW-1:0]              sh_r [NUM_PE];
  logic [AW-1:0]              sh_i [NUM_PE];
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       drop_q, drop_d;
  logic signed [WORD_LEN-1:0] r_q, r_d, i_q, i_d;
  logic [IW-1:0]              idx_q, idx_d, sel_idx;
  logic [AW-1:0]              src_r, src_i;
  logic signed [WORD_LEN-1:0] y_r, y_i;
  logic                       sat_r, sat_i;
  logic                       load, upd, xfer;

  assign xfer = valid_q & out_if.out_ready;

  // Scaler source: live PE0 on capture, otherwise the next shadowed PE.
  always_comb begin
    sel_idx = (idx_q == LAST) ? '0 : idx_q + IW'(1);
    if (state_q == IDLE) begin
      src_r = acc_R[AW-1:0];
      src_i = acc_I[AW-1:0];
    end else begin
      src_r = sh_r[sel_idx];
      src_i = sh_i[sel_idx];
    end
  end

  acc_round_sat #(.WORD_LEN(WORD_LEN), .SHIFT(SHIFT)) u_rs_r (
    .acc (src_r),
    .y   (y_r),
    .sat (sat_r)
  );

  acc_round_sat #(.WORD_LEN(WORD_LEN), .SHIFT(SHIFT)) u_rs_i (
    .acc (src_i),
    .y   (y_i),
    .sat (sat_i)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    r_d     = r_q;
    i_d     = i_q;
    idx_d   = idx_q;
    load    = 1'b0;
    upd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          load    = 1'b1;
          upd     = 1'b1;
          state_d = SEND;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          idx_d   = '0;
          r_d     = y_r;
          i_d     = y_i;
        end
      end
      SEND: begin
        if (capture) drop_d = 1'b1;
        if (xfer) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            upd   = 1'b1;
            idx_d = idx_q + IW'(1);
            r_d   = y_r;
            i_d   = y_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      r_q     <= '0;
      i_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      r_q     <= r_d;
      i_q     <= i_d;
      idx_q   <= idx_d;
    end
  end

  // Shadow copy of the PE row, taken only on an accepted capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_PE); k++) begin
        sh_r[k] <= '0;
        sh_i[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < int'(NUM_PE); k++) begin
        sh_r[k] <= acc_R[k*AW +: AW];
        sh_i[k] <= acc_I[k*AW +: AW];
      end
    end
  end

`ifdef ACC_DRAIN_SAT_CNT_EN
  logic        sat_q;
  logic [15:0] cnt_q;

  // Saturation flag travels with the presented sample; count on its transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (upd) sat_q <= sat_r | sat_i;
      if (xfer && sat_q && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign sat_cnt = cnt_q;
`else
  logic unused_sat;
  assign unused_sat = sat_r ^ sat_i ^ upd;
`endif

  assign busy             = busy_q;
  assign done             = done_q;
  assign capture_drop     = drop_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_R     = r_q;
  assign out_if.out_I     = i_q;
  assign out_if.out_idx   = idx_q;
endmodule

// File: tb/tb_acc_drain.sv
// Self-checking bench for acc_drain: constant vector table, directed
// corner sequences and random traffic against a queue-based reference model.
module tb_acc_drain;
  localparam int unsigned WL   = 24;
  localparam int unsigned NP   = 8;
  localparam int unsigned SH   = 8;
  localparam int unsigned ACCW = 2 * WL;
  localparam longint      SMAX = (longint'(1) <<< (WL - 1)) - 1;
  localparam longint      SMIN = -(longint'(1) <<< (WL - 1));

  logic                 clk;
  logic                 rst_n;
  logic                 capture;
  logic [NP*ACCW-1:0]   acc_R;
  logic [NP*ACCW-1:0]   acc_I;
  logic                 busy;
  logic                 done;
  logic                 capture_drop;
`ifdef ACC_DRAIN_SAT_CNT_EN
  logic [15:0]          sat_cnt;
`endif

  acc_drain_if #(.WORD_LEN(WL), .NUM_PE(NP)) intf ();

  acc_drain #(.WORD_LEN(WL), .NUM_PE(NP), .SHIFT(SH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (capture),
    .acc_R        (acc_R),
    .acc_I        (acc_I),
    .busy         (busy),
    .done         (done),
    .capture_drop (capture_drop),
`ifdef ACC_DRAIN_SAT_CNT_EN
    .sat_cnt      (sat_cnt),
`endif
    .out_if       (intf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    longint r;
    longint i;
    bit     sat;
  } samp_t;

  typedef struct {
    longint ar;
    longint ai;
    longint er;
    longint ei;
  } vec_t;

  int     total = 0;
  int     bad   = 0;
  samp_t  pend[$];
  bit     m_done = 1'b0;
  bit     m_drop = 1'b0;
  int     m_cnt  = 0;
  vec_t   tbl[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference scaling: plain integer arithmetic on the 48-bit value.
  function automatic longint scale(input logic [ACCW-1:0] raw, output bit sat);
    longint v;
    v = $signed(raw);
    if (SH > 0) v = v + (longint'(1) <<< (SH - 1));
    v = v >>> SH;
    sat = 1'b0;
    if (v > SMAX) begin v = SMAX; sat = 1'b1; end
    if (v < SMIN) begin v = SMIN; sat = 1'b1; end
    return v;
  endfunction

  task automatic set_pe(input int k, input longint r, input longint i);
    acc_R[k*ACCW +: ACCW] = ACCW'(r);
    acc_I[k*ACCW +: ACCW] = ACCW'(i);
  endtask

  task automatic rand_acc();
    for (int k = 0; k < int'(NP); k++)
      set_pe(k, $signed({$urandom, $urandom}) >>> $urandom_range(14, 40),
                $signed({$urandom, $urandom}) >>> $urandom_range(14, 40));
  endtask

  task automatic ramp_acc(input longint base);
    for (int k = 0; k < int'(NP); k++) set_pe(k, (base + k) * 256, -(base + k) * 256);
  endtask

  // Model one clock edge: a snapshot is a queue of pending samples.
  task automatic model_edge(input bit cap, input bit rdy);
    samp_t s;
    bit sr, si;
    m_done = 1'b0;
    if (pend.size() > 0) begin
      if (cap) m_drop = 1'b1;
      if (rdy) begin
        if (pend[0].sat && m_cnt != 16'hFFFF) m_cnt++;
        void'(pend.pop_front());
        if (pend.size() == 0) m_done = 1'b1;
      end
    end else if (cap) begin
      for (int k = 0; k < int'(NP); k++) begin
        s.r   = scale(acc_R[k*ACCW +: ACCW], sr);
        s.i   = scale(acc_I[k*ACCW +: ACCW], si);
        s.sat = sr | si;
        pend.push_back(s);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    bit ev;
    ev = pend.size() > 0;
    chk({tag, ".valid"}, longint'(intf.out_valid), longint'(ev));
    chk({tag, ".busy"}, longint'(busy), longint'(ev));
    chk({tag, ".done"}, longint'(done), longint'(m_done));
    chk({tag, ".drop"}, longint'(capture_drop), longint'(m_drop));
    chk({tag, ".idx"}, longint'(intf.out_idx), ev ? longint'(NP - pend.size()) : 0);
    if (ev) begin
      chk({tag, ".R"}, intf.out_R, pend[0].r);
      chk({tag, ".I"}, intf.out_I, pend[0].i);
    end
`ifdef ACC_DRAIN_SAT_CNT_EN
    chk({tag, ".sat_cnt"}, longint'(sat_cnt), longint'(m_cnt));
`endif
  endtask

  // One clock: apply inputs, advance model, check at the falling edge.
  task automatic cycle(input bit cap, input bit rdy, input string tag);
    capture         = cap;
    intf.out_ready  = rdy;
    model_edge(cap, rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
    capture = 1'b0;
  endtask

  task automatic drain(input int mode, input string tag);
    int g;
    bit rdy;
    g = 0;
    while (pend.size() > 0) begin
      if (g >= 200) begin
        chk({tag, ".drain_bound"}, longint'(pend.size()), 0);
        break;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (g % 4 == 0) || (g % 4 == 3);
        default: rdy = $urandom_range(0, 2) != 0;
      endcase
      cycle(1'b0, rdy, tag);
      g++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    pend.delete();
    m_done = 1'b0;
    m_drop = 1'b0;
    m_cnt  = 0;
    check_outputs("rst");
    chk("rst.R0", intf.out_R, 0);
    chk("rst.I0", intf.out_I, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int xfers;
    bit rdy;

    tbl[0] = '{74624, -384, 292, -1};
    tbl[1] = '{64'sd1099511627776, -64'sd1099511627776, 8388607, -8388608};
    tbl[2] = '{127, 128, 0, 1};
    tbl[3] = '{-128, -129, 0, -1};
    tbl[4] = '{64'sd2147483519, 64'sd2147483520, 8388607, 8388607};
    tbl[5] = '{-64'sd2147483776, -64'sd2147483777, -8388608, -8388608};
    tbl[6] = '{64'sd140737488355327, -64'sd140737488355328, 8388607, -8388608};

    rst_n          = 1'b1;
    capture        = 1'b0;
    intf.out_ready = 1'b0;
    acc_R          = '0;
    acc_I          = '0;
    #2;
    do_reset();

    // Scaling vectors on PE0, one capture each, drained with ready high.
    for (int v = 0; v < 7; v++) begin
      rand_acc();
      set_pe(0, tbl[v].ar, tbl[v].ai);
      cycle(1'b1, 1'b1, "tbl.cap");
      chk("tbl.valid", longint'(intf.out_valid), 1);
      chk("tbl.idx0", longint'(intf.out_idx), 0);
      chk("tbl.R", intf.out_R, tbl[v].er);
      chk("tbl.I", intf.out_I, tbl[v].ei);
      drain(0, "tbl.drain");
      cycle(1'b0, 1'b1, "tbl.idle");
    end

    // Full drain of a ramp; sample k must be (k, -k).
    ramp_acc(0);
    cycle(1'b1, 1'b1, "ramp.cap");
    for (int k = 0; k < int'(NP); k++) begin
      chk("ramp.R", intf.out_R, k);
      chk("ramp.I", intf.out_I, -k);
      cycle(1'b0, 1'b1, "ramp");
    end
    chk("ramp.done", longint'(done), 1);
    chk("ramp.busy", longint'(busy), 0);
    cycle(1'b0, 1'b1, "ramp.after");

    // Backpressure with ready pattern 1,0,0,1.
    ramp_acc(10);
    cycle(1'b1, 1'b0, "bp.cap");
    xfers = 0;
    for (int g = 0; g < 64 && pend.size() > 0; g++) begin
      rdy = (g % 4 == 0) || (g % 4 == 3);
      if (intf.out_valid && rdy) xfers++;
      cycle(1'b0, rdy, "bp");
    end
    chk("bp.xfers", xfers, NP);

    // Capture while busy is dropped; capture on the done cycle is accepted.
    ramp_acc(20);
    cycle(1'b1, 1'b1, "drop.cap");
    while (pend.size() > 5) cycle(1'b0, 1'b1, "drop.pre");
    chk("drop.idx3", longint'(intf.out_idx), 3);
    ramp_acc(40);
    cycle(1'b1, 1'b1, "drop.hit");
    chk("drop.set", longint'(capture_drop), 1);
    chk("drop.keep_first", intf.out_R, 24);
    drain(0, "drop.rest");
    chk("drop.done", longint'(done), 1);
    cycle(1'b1, 1'b1, "drop.recap");
    chk("drop.recap_R", intf.out_R, 40);
    drain(1, "drop.drain2");
    chk("drop.sticky", longint'(capture_drop), 1);

    // Reset mid-drain, then a clean drain.
    ramp_acc(60);
    cycle(1'b1, 1'b1, "rmid.cap");
    while (pend.size() > 4) cycle(1'b0, 1'b1, "rmid.pre");
    chk("rmid.idx4", longint'(intf.out_idx), 4);
    do_reset();
    cycle(1'b0, 1'b1, "rmid.nodone");
    ramp_acc(70);
    cycle(1'b1, 1'b1, "rmid.cap2");
    chk("rmid.idx0", longint'(intf.out_idx), 0);
    chk("rmid.R0", intf.out_R, 70);
    drain(0, "rmid.drain");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bit cap;
      cap = $urandom_range(0, 7) == 0;
      if (cap) rand_acc();
      cycle(cap, $urandom_range(0, 2) != 0, "rnd");
    end
    drain(2, "rnd.tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
